// File: rtl/id_decode_pipe_pkg.sv
// Shared decode constants: MIPS opcode/funct encodings, instruction field
// positions and widths of the decoded control bundle.
package id_decode_pipe_pkg;

    localparam int INST_W  = 32;
    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;
    localparam int SHAMT_W = 5;
    localparam int IMM_W   = 16;

    // Instruction field positions
    localparam int OP_MSB    = 31;
    localparam int RS_MSB    = 25;
    localparam int RT_MSB    = 20;
    localparam int RD_MSB    = 15;
    localparam int SHAMT_MSB = 10;
    localparam int FUNCT_MSB = 5;
    localparam int IMM_MSB   = 15;

    localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDIU   = 6'h09;
    localparam logic [OP_W-1:0] OP_ANDI    = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI     = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI    = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI     = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW      = 6'h23;

    localparam logic [FUNCT_W-1:0] FUNCT_NOP  = 6'h00;
    localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'h26;

    typedef struct packed {
        logic [FUNCT_W-1:0] funct;
        logic [SHAMT_W-1:0] shamt;
        logic               mem_read;
        logic               write_en;
    } ctrl_t;

endpackage

// File: rtl/id_decode_pipe_operand_sel.sv
// One register read port: forwarding mux (EX over MEM over regfile) and the
// hazard flag that asks the top to hold IF for this operand.
module id_operand_sel
    import id_decode_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              read_en_i,
    input  logic [REG_AW-1:0] read_addr_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              ex_wen_i,
    input  logic [REG_AW-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_wen_i,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              ld_pending_i,
    input  logic [REG_AW-1:0] ld_waddr_i,
    output logic [DATA_W-1:0] operand_o,
    output logic              hazard_o
);

    logic live;
    logic ex_hit;
    logic mem_hit;
    logic load_use;

    assign live     = read_en_i && (read_addr_i != '0);
    assign ex_hit   = live && ex_wen_i && (ex_waddr_i == read_addr_i);
    assign mem_hit  = live && mem_wen_i && (mem_waddr_i == read_addr_i);
    // The EX bus carries an address, not loaded data, while a LW sits in ID/EX
    assign load_use = live && ld_pending_i && (ld_waddr_i == read_addr_i);

    always_comb begin
        operand_o = reg_data_i;
        if (!live)
            operand_o = '0;
        else if (ex_hit && !load_use && FWD_EN)
            operand_o = ex_wdata_i;
        else if (mem_hit && FWD_EN)
            operand_o = mem_wdata_i;
    end

    assign hazard_o = load_use || (!FWD_EN && (ex_hit || mem_hit));

endmodule

// File: rtl/id_decode_pipe.sv
// Pipelined ID stage: decodes one instruction per cycle, resolves operands
// with forwarding, stalls on load-use and owns the ID/EX register.
module id_decode_pipe
    import id_decode_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic [INST_W-1:0]   if_inst,
    output logic                reg_read_en_1,
    output logic                reg_read_en_2,
    output logic [REG_AW-1:0]   reg_addr_1,
    output logic [REG_AW-1:0]   reg_addr_2,
    input  logic [DATA_W-1:0]   reg_data_1,
    input  logic [DATA_W-1:0]   reg_data_2,
    input  logic                ex_fwd_wen,
    input  logic [REG_AW-1:0]   ex_fwd_waddr,
    input  logic [DATA_W-1:0]   ex_fwd_wdata,
    input  logic                mem_fwd_wen,
    input  logic [REG_AW-1:0]   mem_fwd_waddr,
    input  logic [DATA_W-1:0]   mem_fwd_wdata,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [ADDR_W-1:0]   ex_addr,
    output logic [FUNCT_W-1:0]  ex_funct,
    output logic [SHAMT_W-1:0]  ex_shamt,
    output logic [DATA_W-1:0]   ex_operand_1,
    output logic [DATA_W-1:0]   ex_operand_2,
    output logic                ex_mem_read,
    output logic                ex_write_reg_en,
    output logic [REG_AW-1:0]   ex_write_reg_addr
);

    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [IMM_W-1:0]  imm;

    assign opcode = if_inst[OP_MSB -: OP_W];
    assign rs     = REG_AW'(if_inst[RS_MSB -: 5]);
    assign rt     = REG_AW'(if_inst[RT_MSB -: 5]);
    assign rd     = REG_AW'(if_inst[RD_MSB -: 5]);
    assign imm    = if_inst[IMM_MSB -: IMM_W];

    logic              dec_re1, dec_re2, dec_use_imm;
    logic [DATA_W-1:0] dec_imm;
    logic [REG_AW-1:0] dec_waddr;
    ctrl_t             dec_ctrl;

    always_comb begin
        dec_re1      = 1'b0;
        dec_re2      = 1'b0;
        dec_use_imm  = 1'b0;
        dec_imm      = '0;
        dec_waddr    = '0;
        dec_ctrl     = '0;
        dec_ctrl.funct = FUNCT_NOP;
        case (opcode)
            OP_SPECIAL: begin
                dec_re1        = 1'b1;
                dec_re2        = 1'b1;
                dec_ctrl.funct = if_inst[FUNCT_MSB -: FUNCT_W];
                dec_ctrl.shamt = if_inst[SHAMT_MSB -: SHAMT_W];
                dec_ctrl.write_en = 1'b1;
                dec_waddr      = rd;
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_re1        = 1'b1;
                dec_use_imm    = 1'b1;
                dec_imm[IMM_W-1:0] = imm;
                dec_ctrl.funct = (opcode == OP_ORI)  ? FUNCT_OR :
                                 (opcode == OP_ANDI) ? FUNCT_AND : FUNCT_XOR;
                dec_ctrl.write_en = 1'b1;
                dec_waddr      = rt;
            end
            OP_ADDIU, OP_LW: begin
                dec_re1        = 1'b1;
                dec_use_imm    = 1'b1;
                dec_imm        = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
                dec_ctrl.funct = FUNCT_ADDU;
                dec_ctrl.mem_read = (opcode == OP_LW);
                dec_ctrl.write_en = 1'b1;
                dec_waddr      = rt;
            end
            OP_LUI: begin
                dec_use_imm    = 1'b1;
                dec_imm[31:0]  = {imm, 16'h0000};
                dec_ctrl.funct = FUNCT_OR;
                dec_ctrl.write_en = 1'b1;
                dec_waddr      = rt;
            end
            default: ;
        endcase
        if (dec_waddr == '0)
            dec_ctrl.write_en = 1'b0;
    end

    assign reg_read_en_1 = dec_re1 && !rst;
    assign reg_read_en_2 = dec_re2 && !rst;
    assign reg_addr_1    = reg_read_en_1 ? rs : '0;
    assign reg_addr_2    = reg_read_en_2 ? rt : '0;

    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_addr_q, ex_addr_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    ctrl_t             ctrl_q, ctrl_d;

    logic              ld_pending;
    logic [DATA_W-1:0] sel_op1, sel_op2;
    logic              hz1, hz2, stall, load, fire;

    assign ld_pending = ex_valid_q && ctrl_q.mem_read && ctrl_q.write_en && (waddr_q != '0);

    id_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_sel_1 (
        .read_en_i(reg_read_en_1), .read_addr_i(reg_addr_1), .reg_data_i(reg_data_1),
        .ex_wen_i(ex_fwd_wen), .ex_waddr_i(ex_fwd_waddr), .ex_wdata_i(ex_fwd_wdata),
        .mem_wen_i(mem_fwd_wen), .mem_waddr_i(mem_fwd_waddr), .mem_wdata_i(mem_fwd_wdata),
        .ld_pending_i(ld_pending), .ld_waddr_i(waddr_q),
        .operand_o(sel_op1), .hazard_o(hz1)
    );

    id_operand_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_sel_2 (
        .read_en_i(reg_read_en_2), .read_addr_i(reg_addr_2), .reg_data_i(reg_data_2),
        .ex_wen_i(ex_fwd_wen), .ex_waddr_i(ex_fwd_waddr), .ex_wdata_i(ex_fwd_wdata),
        .mem_wen_i(mem_fwd_wen), .mem_waddr_i(mem_fwd_waddr), .mem_wdata_i(mem_fwd_wdata),
        .ld_pending_i(ld_pending), .ld_waddr_i(waddr_q),
        .operand_o(sel_op2), .hazard_o(hz2)
    );

    assign stall    = hz1 || hz2;
    assign load     = !ex_valid_q || ex_ready;
    // Flush consumes the IF instruction even while stalled or back-pressured
    assign if_ready = !rst && ((load && !stall) || flush);
    assign fire     = if_valid && if_ready;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_addr_d  = ex_addr_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        waddr_d    = waddr_q;
        ctrl_d     = ctrl_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (load) begin
            ex_valid_d = fire;
            if (fire) begin
                ex_addr_d = if_addr;
                op1_d     = sel_op1;
                op2_d     = dec_use_imm ? dec_imm : sel_op2;
                waddr_d   = dec_waddr;
                ctrl_d    = dec_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_addr_q  <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            waddr_q    <= '0;
            ctrl_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_addr_q  <= ex_addr_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            waddr_q    <= waddr_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign ex_valid          = ex_valid_q;
    assign ex_addr           = ex_addr_q;
    assign ex_funct          = ctrl_q.funct;
    assign ex_shamt          = ctrl_q.shamt;
    assign ex_operand_1      = op1_q;
    assign ex_operand_2      = op2_q;
    assign ex_mem_read       = ctrl_q.mem_read;
    assign ex_write_reg_en   = ctrl_q.write_en;
    assign ex_write_reg_addr = waddr_q;

endmodule
